// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write integer register file with a
// hard-wired zero register, optional write-to-read bypass and a per-register
// pending-write scoreboard. After reset or a clear request the file sweeps
// every entry to zero, one entry per clock. This lets the storage map onto
// RAM without a per-entry reset.
//
// Ports:
//   clk_i               clock, all state changes on the rising edge
//   rst_i               synchronous active-high reset
//   clear_i             request a full sweep-clear (only honoured when ready)
//   wr_en_i/wr_addr_i/wr_data_i   writeback port, also clears the pending bit
//   iss_en_i/iss_rd_i   issue port, marks the destination register pending
//   rs1_addr_i/rs2_addr_i         read indices
//   rs1_data_o/rs2_data_o         combinational read data
//   rs1_busy_o/rs2_busy_o         pending-write flag of the addressed register
//   ready_o             1 once the sweep has finished and the file is usable
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              ready_o
);

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic              state;
  logic [ADDR_W-1:0] sidx;
  logic [NREGS-1:0]  pend;
  logic [XLEN-1:0]   store [NREGS];

  logic ready;
  logic wr_ok;
  logic iss_ok;
  logic byp1;
  logic byp2;

  assign ready   = (state == ST_READY);
  assign ready_o = ready;

  // Writes and issues to index 0 are discarded. A clear request takes
  // priority over a same-cycle write.
  assign wr_ok  = ready && !clear_i && wr_en_i && (wr_addr_i != '0);
  assign iss_ok = ready && !clear_i && iss_en_i && (iss_rd_i != '0);

  // Control state and scoreboard (with reset).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_INIT;
      sidx  <= '0;
      pend  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sidx == LAST_IDX) begin
            state <= ST_READY;
            sidx  <= '0;
          end else begin
            sidx <= sidx + 1'b1;
          end
        end
        default: begin
          if (clear_i) begin
            state <= ST_INIT;
            sidx  <= '0;
            pend  <= '0;
          end else begin
            if (wr_ok)
              pend[wr_addr_i] <= 1'b0;
            // Issue is evaluated last: a same-edge issue to the written
            // register leaves it pending.
            if (iss_ok)
              pend[iss_rd_i] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage has no reset. The sweep zeroes one entry per INIT edge, and it
  // never writes on a reset edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == ST_INIT)
        store[sidx] <= '0;
      else if (wr_ok)
        store[wr_addr_i] <= wr_data_i;
    end
  end

  assign byp1 = (BYPASS != 0) && wr_en_i && (wr_addr_i == rs1_addr_i);
  assign byp2 = (BYPASS != 0) && wr_en_i && (wr_addr_i == rs2_addr_i);

  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    if (ready && (rs1_addr_i != '0)) begin
      if (byp1) begin
        rs1_data_o = wr_data_i;
      end else begin
        rs1_data_o = store[rs1_addr_i];
        rs1_busy_o = pend[rs1_addr_i];
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (ready && (rs2_addr_i != '0)) begin
      if (byp2) begin
        rs2_data_o = wr_data_i;
      end else begin
        rs2_data_o = store[rs2_addr_i];
        rs2_busy_o = pend[rs2_addr_i];
      end
    end
  end

endmodule
